// File: rtl/tl_sched.sv
// -----------------------------------------------------------------------------
// tl_sched -- phase scheduler for a two-street intersection with a pedestrian
// crossing. Owns the signal heads and arbitrates between street A traffic,
// street B traffic and pedestrian requests. It enforces minimum green, maximum
// green (anti-starvation), a fixed yellow interval and a fixed all-red walk
// interval.
//
// Configuration macro: TL_SCHED_PED_EN
//   defined   : pedestrian latch, WALK state, walk and ped_ack outputs are built
//   undefined : ped_req is ignored, walk/ped_ack are tied 0, and yellow goes
//               straight to the opposite green
//
// Parameters
//   MIN_GREEN  minimum green length in cycles       (1..31)
//   MAX_GREEN  green length before a forced change  (MIN_GREEN..31)
//   YELLOW_T   yellow length in cycles              (1..31)
//   WALK_T     all-red walk length in cycles        (1..31)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   Ta       in   traffic present on street A
//   Tb       in   traffic present on street B
//   ped_req  in   pedestrian request (pulse of any length)
//   La       out  street A head: 00 green, 01 yellow, 10 red
//   Lb       out  street B head, same encoding
//   walk     out  walk indication
//   ped_ack  out  one-cycle pulse in the first walk cycle
// -----------------------------------------------------------------------------
module tl_sched #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic       ped_ack
);

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;

  // Thresholds are compared against the timer value of the current cycle, so
  // an interval of N cycles ends when the timer reads N-1.
  localparam logic [4:0] L_MIN_M1  = 5'(MIN_GREEN - 1);
  localparam logic [4:0] L_MAX_M1  = 5'(MAX_GREEN - 1);
  localparam logic [4:0] L_YEL_M1  = 5'(YELLOW_T - 1);
  localparam logic [4:0] L_TIM_MAX = 5'd31;

  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_BG = 3'd2,
    S_BY = 3'd3
`ifdef TL_SCHED_PED_EN
    , S_WALK = 3'd4
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_timer;
  logic       w_pend;
  logic       w_a_exit;
  logic       w_b_exit;

`ifdef TL_SCHED_PED_EN
  localparam logic [4:0] L_WALK_M1 = 5'(WALK_T - 1);

  logic r_ped_pend;
  logic r_nxt_b;      // street served after WALK: 1 = B, 0 = A
  logic w_enter_walk;

  assign w_pend       = r_ped_pend;
  assign w_enter_walk = (w_state_nxt == S_WALK) && (r_state != S_WALK);
`else
  logic w_unused_ped;

  assign w_pend       = 1'b0;
  assign w_unused_ped = ped_req;
`endif

  // A green may end only after its minimum length, and only if someone else
  // is waiting. It ends early when its own street has gone quiet, or at max
  // green regardless of its own traffic.
  assign w_a_exit = (r_timer >= L_MIN_M1) && (Tb || w_pend) &&
                    (!Ta || (r_timer >= L_MAX_M1));
  assign w_b_exit = (r_timer >= L_MIN_M1) && (Ta || w_pend) &&
                    (!Tb || (r_timer >= L_MAX_M1));

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a value unassigned (no latch inferred).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_AG: if (w_a_exit) w_state_nxt = S_AY;
      S_BG: if (w_b_exit) w_state_nxt = S_BY;
`ifdef TL_SCHED_PED_EN
      S_AY: if (r_timer == L_YEL_M1) w_state_nxt = w_pend ? S_WALK : S_BG;
      S_BY: if (r_timer == L_YEL_M1) w_state_nxt = w_pend ? S_WALK : S_AG;
      S_WALK: if (r_timer == L_WALK_M1) w_state_nxt = r_nxt_b ? S_BG : S_AG;
`else
      S_AY: if (r_timer == L_YEL_M1) w_state_nxt = S_BG;
      S_BY: if (r_timer == L_YEL_M1) w_state_nxt = S_AG;
`endif
      default: w_state_nxt = S_AG;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_AG;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)    r_timer <= '0;
      else if (r_timer != L_TIM_MAX) r_timer <= r_timer + 5'd1;
    end
  end

`ifdef TL_SCHED_PED_EN
  // A request arriving in the same cycle as the entry into WALK is kept:
  // that walk was decided on the older request, so this one waits for the
  // next green to finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_pend <= 1'b0;
      r_nxt_b    <= 1'b1;
    end else begin
      r_ped_pend <= (ped_req && (r_state != S_WALK)) ||
                    (r_ped_pend && !w_enter_walk);
      if ((r_state == S_AG) && (w_state_nxt == S_AY))      r_nxt_b <= 1'b1;
      else if ((r_state == S_BG) && (w_state_nxt == S_BY)) r_nxt_b <= 1'b0;
    end
  end
`endif

  // Moore decode of the heads from the registered state.
  always_comb begin
    La      = C_RED;
    Lb      = C_RED;
    walk    = 1'b0;
    ped_ack = 1'b0;
    case (r_state)
      S_AG: La = C_GREEN;
      S_AY: La = C_YELLOW;
      S_BG: Lb = C_GREEN;
      S_BY: Lb = C_YELLOW;
`ifdef TL_SCHED_PED_EN
      S_WALK: begin
        walk    = 1'b1;
        ped_ack = (r_timer == 5'd0);
      end
`endif
      default: begin
        La = C_RED;
        Lb = C_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_tl_sched.sv
// -----------------------------------------------------------------------------
// tb_tl_sched -- self-checking bench for tl_sched (default parameters).
// Outputs are compared every cycle against an interval-based reference model
// (kind of interval, served street, age in cycles), plus directed checks at
// the points called out for each scenario. Works with or without
// TL_SCHED_PED_EN; the expectations follow the same macro.
// -----------------------------------------------------------------------------
module tb_tl_sched;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 10;
  localparam int YELLOW_T  = 2;
  localparam int WALK_T    = 3;

  localparam int K_GREEN  = 0;
  localparam int K_YELLOW = 1;
  localparam int K_WALK   = 2;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       Ta      = 1'b0;
  logic       Tb      = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic       ped_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: what kind of interval is running, for which street
  // (0 = A, 1 = B), how many cycles it has lasted, and who goes next.
  int m_kind;
  int m_street;
  int m_after;
  int m_age;
  bit m_pend;

  tl_sched #(
    .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN),
    .YELLOW_T (YELLOW_T),
    .WALK_T   (WALK_T)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Ta     (Ta),
    .Tb     (Tb),
    .ped_req(ped_req),
    .La     (La),
    .Lb     (Lb),
    .walk   (walk),
    .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed La_Lb_walk_ack=%b required %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [1:0] la, lb;
    logic       w, a;
    la = 2'b10;
    lb = 2'b10;
    w  = 1'b0;
    a  = 1'b0;
    case (m_kind)
      K_GREEN:  if (m_street == 0) la = 2'b00; else lb = 2'b00;
      K_YELLOW: if (m_street == 0) la = 2'b01; else lb = 2'b01;
      default: begin
        w = 1'b1;
        a = (m_age == 0);
      end
    endcase
    return {la, lb, w, a};
  endfunction

  task automatic model_step(input bit ta, input bit tb, input bit pr, input bit rst);
    int nk, ns;
    bit to_walk, own, comp;
    if (rst) begin
      m_kind   = K_GREEN;
      m_street = 0;
      m_after  = 1;
      m_age    = 0;
      m_pend   = 1'b0;
      return;
    end
    nk      = m_kind;
    ns      = m_street;
    to_walk = 1'b0;
    own     = (m_street == 0) ? ta : tb;
    comp    = ((m_street == 0) ? tb : ta) | m_pend;
    case (m_kind)
      K_GREEN:
        if (m_age >= MIN_GREEN - 1 && comp && (!own || m_age >= MAX_GREEN - 1)) begin
          nk      = K_YELLOW;
          m_after = 1 - m_street;
        end
      K_YELLOW:
        if (m_age == YELLOW_T - 1) begin
          if (m_pend) begin
            nk      = K_WALK;
            to_walk = 1'b1;
          end else begin
            nk = K_GREEN;
            ns = m_after;
          end
        end
      default:
        if (m_age == WALK_T - 1) begin
          nk = K_GREEN;
          ns = m_after;
        end
    endcase
`ifdef TL_SCHED_PED_EN
    m_pend = (pr && m_kind != K_WALK) || (m_pend && !to_walk);
`else
    m_pend = pr & 1'b0;
`endif
    m_age    = (nk != m_kind || ns != m_street) ? 0 : m_age + 1;
    m_kind   = nk;
    m_street = ns;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the outputs of
  // this cycle with the model, advance the model, cross the rising edge.
  task automatic cycle(input int scen, input int k, input bit ta, input bit tb,
                       input bit pr, input bit rst);
    Ta      = ta;
    Tb      = tb;
    ped_req = pr;
    reset   = rst;
    check($sformatf("s%0d_c%0d_model", scen, k), {La, Lb, walk, ped_ack}, model_out());
    model_step(ta, tb, pr, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_state", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);

    // Scenario 1: only street A has traffic -- A stays green.
    for (int k = 0; k < 30; k++) begin
      if (k == 29) check("s1_c29_hold_a", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      cycle(1, k, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Scenario 2: only street B has traffic -- A leaves at min green.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) check("s2_c3_last_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 4) check("s2_c4_yellow", {La, Lb, walk, ped_ack}, 6'b01_10_0_0);
      if (k == 5) check("s2_c5_yellow", {La, Lb, walk, ped_ack}, 6'b01_10_0_0);
      if (k == 6) check("s2_c6_b_green", {La, Lb, walk, ped_ack}, 6'b10_00_0_0);
      cycle(2, k, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Scenario 3: both streets busy -- max green alternation, period 24.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 50; k++) begin
      if (k == 9)  check("s3_c9_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 10) check("s3_c10_a_yellow", {La, Lb, walk, ped_ack}, 6'b01_10_0_0);
      if (k == 12) check("s3_c12_b_green", {La, Lb, walk, ped_ack}, 6'b10_00_0_0);
      if (k == 21) check("s3_c21_b_green", {La, Lb, walk, ped_ack}, 6'b10_00_0_0);
      if (k == 22) check("s3_c22_b_yellow", {La, Lb, walk, ped_ack}, 6'b10_01_0_0);
      if (k == 24) check("s3_c24_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 48) check("s3_c48_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      cycle(3, k, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Scenario 4: A busy, one-cycle pedestrian request at cycle 1.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
`ifdef TL_SCHED_PED_EN
      if (k == 9)  check("s4_c9_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 11) check("s4_c11_a_yellow", {La, Lb, walk, ped_ack}, 6'b01_10_0_0);
      if (k == 12) check("s4_c12_walk_ack", {La, Lb, walk, ped_ack}, 6'b10_10_1_1);
      if (k == 13) check("s4_c13_walk", {La, Lb, walk, ped_ack}, 6'b10_10_1_0);
      if (k == 14) check("s4_c14_walk", {La, Lb, walk, ped_ack}, 6'b10_10_1_0);
      if (k == 15) check("s4_c15_b_green", {La, Lb, walk, ped_ack}, 6'b10_00_0_0);
`else
      if (k == 12) check("s4_c12_no_walk", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 19) check("s4_c19_no_walk", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
`endif
      cycle(4, k, 1'b1, 1'b0, (k == 1), 1'b0);
    end

    // Scenario 5: reset mid-yellow drops the pending pedestrian request.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 36; k++) begin
      if (k == 6)  check("s5_c6_after_reset", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      if (k == 35) check("s5_c35_no_walk", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
      cycle(5, k, (k >= 5), (k < 5), (k == 1), (k == 5));
    end

    // Scenario 6: request during the last yellow cycle is kept for the next
    // walk; requests during WALK are ignored.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
`ifdef TL_SCHED_PED_EN
      if (k == 21) check("s6_c21_second_walk", {La, Lb, walk, ped_ack}, 6'b10_10_1_1);
      if (k == 24) check("s6_c24_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
`else
      if (k == 21) check("s6_c21_a_green", {La, Lb, walk, ped_ack}, 6'b00_10_0_0);
`endif
      cycle(6, k, 1'b1, 1'b0, (k == 1 || (k >= 11 && k <= 14)), 1'b0);
    end

    // Scenario 7: random traffic, pedestrian requests and occasional resets.
    cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 800; k++) begin
      cycle(7, k, ($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 16) == 0, ($urandom % 128) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
